// File: rtl/instruction_writer_pkg.sv
// Shared ISA definitions for the instruction writer: field widths, field bit
// positions within the 16-bit program word, FSM state encoding, and field
// extraction helpers for the decode side.
package instruction_writer_pkg;

    localparam int unsigned OPCODE_W  = 7;
    localparam int unsigned OPERAND_W = 3;
    localparam int unsigned WORD_W    = 16;

    localparam int unsigned OPCODE_LSB = 9;
    localparam int unsigned OP0_LSB    = 6;
    localparam int unsigned OP1_LSB    = 3;
    localparam int unsigned OP2_LSB    = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        WRITE = 2'd2
    } state_t;

    function automatic logic [OPCODE_W-1:0] word_opcode(input logic [WORD_W-1:0] w);
        return w[OPCODE_LSB +: OPCODE_W];
    endfunction

    function automatic logic [OPERAND_W-1:0] word_op0(input logic [WORD_W-1:0] w);
        return w[OP0_LSB +: OPERAND_W];
    endfunction

    function automatic logic [OPERAND_W-1:0] word_op1(input logic [WORD_W-1:0] w);
        return w[OP1_LSB +: OPERAND_W];
    endfunction

    function automatic logic [OPERAND_W-1:0] word_op2(input logic [WORD_W-1:0] w);
        return w[OP2_LSB +: OPERAND_W];
    endfunction

endpackage

// File: rtl/instruction_writer_if.sv
// Session, field handshake and memory-write bus of the instruction writer.
// Optional checksum signal present only when INSTR_WRITER_CHECKSUM_EN is defined.
interface instruction_writer_if
    import instruction_writer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] startAddr;
    logic                  finish;
    logic                  inValid;
    logic                  inReady;
    logic [OPCODE_W-1:0]   inOpcode;
    logic [OPERAND_W-1:0]  inOp0;
    logic [OPERAND_W-1:0]  inOp1;
    logic [OPERAND_W-1:0]  inOp2;
    logic [ADDR_WIDTH-1:0] outAddr;
    logic [WORD_W-1:0]     outData;
    logic                  notWrite;
    logic                  memAck;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] count;
    logic                  overflow;
`ifdef INSTR_WRITER_CHECKSUM_EN
    logic [WORD_W-1:0]     checksum;

    modport master (
        output start, startAddr, finish, inValid, inOpcode, inOp0, inOp1, inOp2, memAck,
        input  inReady, outAddr, outData, notWrite, busy, done, count, overflow, checksum
    );
    modport slave (
        input  start, startAddr, finish, inValid, inOpcode, inOp0, inOp1, inOp2, memAck,
        output inReady, outAddr, outData, notWrite, busy, done, count, overflow, checksum
    );
`else
    modport master (
        output start, startAddr, finish, inValid, inOpcode, inOp0, inOp1, inOp2, memAck,
        input  inReady, outAddr, outData, notWrite, busy, done, count, overflow
    );
    modport slave (
        input  start, startAddr, finish, inValid, inOpcode, inOp0, inOp1, inOp2, memAck,
        output inReady, outAddr, outData, notWrite, busy, done, count, overflow
    );
`endif
endinterface

// File: rtl/instruction_writer_packer.sv
// Combinational packing of instruction fields into one program word.
module instruction_packer
    import instruction_writer_pkg::*;
(
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic [OPERAND_W-1:0] op0,
    input  logic [OPERAND_W-1:0] op1,
    input  logic [OPERAND_W-1:0] op2,
    output logic [WORD_W-1:0]    word
);
    // Place each field at its package-defined bit position.
    always_comb begin
        word = '0;
        word[OPCODE_LSB +: OPCODE_W] = opcode;
        word[OP0_LSB +: OPERAND_W]   = op0;
        word[OP1_LSB +: OPERAND_W]   = op1;
        word[OP2_LSB +: OPERAND_W]   = op2;
    end
endmodule

// File: rtl/instruction_writer.sv
// Instruction writer: accepts instruction fields over a valid/ready handshake,
// packs them and writes them to sequential program-memory addresses, holding
// each write until memAck. All outputs are registered.
// Optional running checksum of written words: INSTR_WRITER_CHECKSUM_EN.
module instruction_writer
    import instruction_writer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16
)(
    input logic clock,
    input logic reset,
    instruction_writer_if.slave bus
);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_W-1:0]     data_q, data_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  pend_q, pend_d;
    logic                  done_q, done_d;
    logic                  ready_q, busy_q, nwr_q;
    logic [WORD_W-1:0]     packed_word;
`ifdef INSTR_WRITER_CHECKSUM_EN
    logic [WORD_W-1:0]     csum_q, csum_d;
`endif

    instruction_packer u_packer (
        .opcode (bus.inOpcode),
        .op0    (bus.inOp0),
        .op1    (bus.inOp1),
        .op2    (bus.inOp2),
        .word   (packed_word)
    );

    // Next-state and next-register values for the session FSM.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
`ifdef INSTR_WRITER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ARMED;
                    addr_d  = bus.startAddr;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    pend_d  = 1'b0;
`ifdef INSTR_WRITER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            ARMED: begin
                if (bus.inValid) begin
                    data_d  = packed_word;
                    state_d = WRITE;
                    if (bus.finish) pend_d = 1'b1;
                end else if (bus.finish) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            WRITE: begin
                if (bus.finish) pend_d = 1'b1;
                if (bus.memAck) begin
                    addr_d = addr_q + ADDR_ONE;
                    if (addr_q == '1) ovf_d = 1'b1;
                    if (count_q != '1) count_d = count_q + ADDR_ONE;
`ifdef INSTR_WRITER_CHECKSUM_EN
                    csum_d = csum_q + data_q;
`endif
                    // A finish seen with or during this word closes the session here.
                    if (pend_q || bus.finish) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = ARMED;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; strobes derive from the next state so they
    // change on the same edge as the state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            nwr_q   <= 1'b1;
`ifdef INSTR_WRITER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            ready_q <= (state_d == ARMED);
            busy_q  <= (state_d != IDLE);
            nwr_q   <= (state_d != WRITE);
`ifdef INSTR_WRITER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign bus.inReady  = ready_q;
    assign bus.outAddr  = addr_q;
    assign bus.outData  = data_q;
    assign bus.notWrite = nwr_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;
`ifdef INSTR_WRITER_CHECKSUM_EN
    assign bus.checksum = csum_q;
`endif
endmodule

// File: tb/tb_instruction_writer.sv
// Directed self-checking bench for instruction_writer: table of single-word
// sessions plus hand-written multi-cycle sequences.
module tb_instruction_writer;
    import instruction_writer_pkg::*;

    logic clock;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    instruction_writer_if #(.ADDR_WIDTH(16)) bus ();

    instruction_writer #(.ADDR_WIDTH(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] start_addr;
        logic [6:0]  opc;
        logic [2:0]  a;
        logic [2:0]  b;
        logic [2:0]  c;
        int          ack_delay;
        logic [15:0] exp_word;
    } vec_t;

    vec_t vecs [6];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [6:0] opc, input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
        bus.inValid  = 1'b1;
        bus.inOpcode = opc;
        bus.inOp0    = a;
        bus.inOp1    = b;
        bus.inOp2    = c;
        step();
        bus.inValid  = 1'b0;
    endtask

    task automatic ack();
        bus.memAck = 1'b1;
        step();
        bus.memAck = 1'b0;
    endtask

    task automatic open_session(input logic [15:0] addr);
        bus.start     = 1'b1;
        bus.startAddr = addr;
        step();
        bus.start     = 1'b0;
    endtask

    initial begin
        int low;
        logic [15:0] next_addr;

        vecs[0] = '{16'h0100, 7'h05, 3'd1, 3'd2, 3'd3, 2, 16'h0A53};
        vecs[1] = '{16'h1234, 7'h7F, 3'd7, 3'd7, 3'd7, 0, 16'hFFFF};
        vecs[2] = '{16'h0000, 7'h00, 3'd0, 3'd0, 3'd0, 1, 16'h0000};
        vecs[3] = '{16'h8000, 7'h40, 3'd0, 3'd0, 3'd1, 3, 16'h8001};
        vecs[4] = '{16'h00FF, 7'h2A, 3'd5, 3'd0, 3'd6, 1, 16'h5546};
        vecs[5] = '{16'h4000, 7'h01, 3'd0, 3'd7, 3'd0, 2, 16'h0238};

        reset = 1'b1;
        bus.start = 1'b0; bus.startAddr = '0; bus.finish = 1'b0;
        bus.inValid = 1'b0; bus.inOpcode = '0; bus.inOp0 = '0; bus.inOp1 = '0; bus.inOp2 = '0;
        bus.memAck = 1'b0;
        #1;
        check("rst_notWrite", bus.notWrite, 1);
        check("rst_inReady", bus.inReady, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_count", bus.count, 0);
        check("rst_outAddr", bus.outAddr, 0);
        check("rst_outData", bus.outData, 0);
        step();
        step();
        reset = 1'b0;
        step();

        // Single-word sessions from the table.
        for (int i = 0; i < 6; i++) begin
            open_session(vecs[i].start_addr);
            check("arm_busy", bus.busy, 1);
            check("arm_ready", bus.inReady, 1);
            check("arm_count", bus.count, 0);
            check("arm_addr", bus.outAddr, vecs[i].start_addr);
            send(vecs[i].opc, vecs[i].a, vecs[i].b, vecs[i].c);
            check("wr_data", bus.outData, vecs[i].exp_word);
            check("wr_addr", bus.outAddr, vecs[i].start_addr);
            check("wr_ready", bus.inReady, 0);
            check("wr_opcode_field", word_opcode(bus.outData), vecs[i].opc);
            low = 0;
            for (int k = 0; k <= vecs[i].ack_delay; k++) begin
                if (bus.notWrite == 1'b0) low++;
                if (k == vecs[i].ack_delay) begin
                    check("wr_hold_data", bus.outData, vecs[i].exp_word);
                    bus.memAck = 1'b1;
                end
                step();
            end
            bus.memAck = 1'b0;
            next_addr = vecs[i].start_addr + 16'd1;
            check("low_cycles", low, vecs[i].ack_delay + 1);
            check("ack_notWrite", bus.notWrite, 1);
            check("ack_count", bus.count, 1);
            check("ack_addr", bus.outAddr, next_addr);
            check("ack_ready", bus.inReady, 1);
            bus.finish = 1'b1;
            step();
            bus.finish = 1'b0;
            check("fin_done", bus.done, 1);
            check("fin_busy", bus.busy, 0);
            step();
            check("fin_done_low", bus.done, 0);
        end

        // Back-to-back words with memAck held high: one write per two cycles.
        open_session(16'h0100);
        bus.memAck   = 1'b1;
        bus.inValid  = 1'b1;
        bus.inOp0 = '0; bus.inOp1 = '0; bus.inOp2 = '0;
        for (int w = 0; w < 3; w++) begin
            bus.inOpcode = 7'(w + 1);
            step();
            check("b2b_write", bus.notWrite, 0);
            check("b2b_ready", bus.inReady, 0);
            check("b2b_addr", bus.outAddr, 16'h0100 + 16'(w));
            check("b2b_data", bus.outData, 16'((w + 1) * 512));
            step();
            check("b2b_ack", bus.notWrite, 1);
            check("b2b_rearm", bus.inReady, 1);
        end
        bus.inValid = 1'b0;
        bus.memAck  = 1'b0;
        check("b2b_count", bus.count, 3);
        bus.finish = 1'b1;
        step();
        bus.finish = 1'b0;
        check("b2b_done", bus.done, 1);
        step();

        // finish together with the second word's transfer.
        open_session(16'h0200);
        send(7'h11, 3'd1, 3'd1, 3'd1);
        ack();
        bus.finish = 1'b1;
        send(7'h22, 3'd2, 3'd2, 3'd2);
        bus.finish = 1'b0;
        check("pf_write", bus.notWrite, 0);
        check("pf_addr", bus.outAddr, 16'h0201);
        check("pf_no_early_done", bus.done, 0);
        ack();
        check("pf_done", bus.done, 1);
        check("pf_idle_busy", bus.busy, 0);
        check("pf_idle_ready", bus.inReady, 0);
        check("pf_count", bus.count, 2);
        bus.inValid = 1'b1;
        step();
        bus.inValid = 1'b0;
        check("pf_done_once", bus.done, 0);
        check("pf_no_third", bus.notWrite, 1);

        // Address wrap, ignored memAck/start, finish during WRITE.
        open_session(16'hFFFF);
        bus.memAck = 1'b1;
        step();
        bus.memAck = 1'b0;
        check("ign_ack_addr", bus.outAddr, 16'hFFFF);
        check("ign_ack_count", bus.count, 0);
        send(7'h03, 3'd0, 3'd0, 3'd0);
        bus.start = 1'b1;
        bus.startAddr = 16'h1234;
        step();
        bus.start = 1'b0;
        check("ign_start_addr", bus.outAddr, 16'hFFFF);
        check("ign_start_write", bus.notWrite, 0);
        ack();
        check("wrap_addr", bus.outAddr, 16'h0000);
        check("wrap_ovf", bus.overflow, 1);
        send(7'h04, 3'd0, 3'd0, 3'd0);
        check("wrap_wr_addr", bus.outAddr, 16'h0000);
        bus.finish = 1'b1;
        step();
        bus.finish = 1'b0;
        check("wf_still_write", bus.notWrite, 0);
        ack();
        check("wf_done", bus.done, 1);
        check("wf_ovf_held", bus.overflow, 1);
        check("wf_addr", bus.outAddr, 16'h0001);
        step();
        open_session(16'h0010);
        check("ovf_clear", bus.overflow, 0);
        check("count_clear", bus.count, 0);
        bus.finish = 1'b1;
        step();
        bus.finish = 1'b0;
        step();

        // Reset asserted in the middle of a write.
        open_session(16'h0300);
        send(7'h55, 3'd1, 3'd0, 3'd1);
        check("pre_rst_write", bus.notWrite, 0);
        #1;
        reset = 1'b1;
        #1;
        check("async_notWrite", bus.notWrite, 1);
        check("async_busy", bus.busy, 0);
        check("async_addr", bus.outAddr, 0);
        bus.memAck = 1'b1;
        step();
        reset = 1'b0;
        step();
        step();
        bus.memAck = 1'b0;
        check("post_rst_notWrite", bus.notWrite, 1);
        check("post_rst_busy", bus.busy, 0);
        check("post_rst_count", bus.count, 0);

`ifdef INSTR_WRITER_CHECKSUM_EN
        open_session(16'h0400);
        check("csum_clear", bus.checksum, 0);
        send(7'h40, 3'd0, 3'd0, 3'd1);
        ack();
        send(7'h40, 3'd0, 3'd0, 3'd2);
        ack();
        check("csum_sum", bus.checksum, 16'h0003);
        bus.finish = 1'b1;
        step();
        bus.finish = 1'b0;
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/instruction_writer.md
INSTRUCTION_WRITER -- requirements
Module: instruction_writer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, program-memory address width.
REQ-002 SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports start  in  1 (open session) and startAddr  in  ADDR_WIDTH (first write address, sampled with start).
REQ-005 SHALL have port finish  in  1  close the session after any in-flight word.
REQ-006 SHALL have ports inValid  in  1 and inReady  out  1  field handshake; transfer when both are high on a clock edge.
REQ-007 SHALL have ports inOpcode  in  7 and inOp0, inOp1, inOp2  in  3 each  instruction fields.
REQ-008 SHALL have ports outAddr  out  ADDR_WIDTH and outData  out  16  memory write address and data.
REQ-009 SHALL have ports notWrite  out  1 (active-low write strobe) and memAck  in  1 (memory accepted the write).
REQ-010 SHALL have ports busy  out  1, done  out  1, count  out  ADDR_WIDTH (words written this session) and overflow  out  1.

Function
REQ-011 SHALL pack the 16-bit word as {inOpcode, inOp0, inOp1, inOp2}: opcode in bits 15:9, op0 in 8:6, op1 in 5:3, op2 in 2:0.
REQ-012 SHALL implement states IDLE, ARMED, WRITE; all outputs SHALL be registered.
REQ-013 IDLE: busy=0, inReady=0, notWrite=1; start -> ARMED, load address from startAddr, count=0, overflow=0.
REQ-014 ARMED: busy=1, inReady=1; accepted transfer -> latch packed word, go to WRITE.
REQ-015 WRITE: inReady=0, notWrite=0, outAddr=current address, outData=latched word; both stay stable until memAck.
REQ-016 Latency: a word accepted on edge N SHALL produce notWrite=0 from edge N on, i.e. visible in cycle N+1.
REQ-017 memAck=1 in WRITE: notWrite returns to 1 on the same edge, address+1, count+1, next state ARMED; memAck outside WRITE SHALL be ignored.
REQ-018 finish in ARMED with inValid=0: go to IDLE and pulse done for exactly one cycle.
REQ-019 finish in WRITE, or together with an accepted transfer in ARMED: set pendingFinish; on memAck go to IDLE (not ARMED) and pulse done.
REQ-020 start outside IDLE SHALL be ignored.
REQ-021 Address increment from all-ones SHALL wrap to 0 and set overflow; overflow stays set until the next start.
REQ-022 count SHALL saturate at all-ones.

Reset
REQ-023 reset SHALL force IDLE immediately, without waiting for a clock edge, aborting any write.
REQ-024 Reset values: notWrite=1, inReady=0, busy=0, done=0, overflow=0, count=0, outAddr=0, outData=0, pendingFinish=0.

Configuration
REQ-025 With INSTR_WRITER_CHECKSUM_EN defined, SHALL add output checksum  out  16: cleared on start and reset, plus outData modulo 2^16 on every memAck in WRITE.
REQ-026 Without INSTR_WRITER_CHECKSUM_EN, the checksum port and its logic SHALL not exist; all other behaviour is identical.

Structure
REQ-027 Shared ISA package SHALL hold the field widths (opcode 7, operand 3, word 16), field bit positions and the state encoding constants.
REQ-028 Word packing SHALL be one sub-module, instruction_packer (combinational, fields in, word out); the decode side SHALL use the same field positions.

Verification
REQ-029 start, startAddr=0x0100; send opcode=0x05, op0=1, op1=2, op2=3; memAck after 2 cycles -> outData=0x0A53, outAddr=0x0100, notWrite low 3 cycles, count=1.
REQ-030 Three back-to-back words with memAck held high -> writes to 0x0100, 0x0101, 0x0102, one per 2 cycles; inReady=0 during each WRITE.
REQ-031 finish with the 2nd word's transfer -> that word is written, then IDLE, done high exactly 1 cycle, no 3rd write.
REQ-032 startAddr=0xFFFF; two words -> addresses 0xFFFF then 0x0000, overflow=1 after the first memAck.
REQ-033 reset asserted mid-WRITE -> notWrite=1 and busy=0 before the next clock edge; later memAck has no effect.
REQ-034 Checksum macro defined; words 0x8001 and 0x8002 -> checksum=0x0003; without the macro the netlist has no checksum port.
